shifter_sequencer_64: RTL and testbench

Multi-cycle 64-bit shift/rotate unit built around a 32-bit funnel-shift datapath. Sits directly upstream of the 32-bit funnel shifter stage and reuses its control encoding. It accepts one 64-bit request over a valid/ready handshake. It computes the low result word and then the high result word in two successive cycles, and presents the registered 64-bit result over an output valid/ready handshake.

---
 rtl/shifter_sequencer_64_if.sv | 30 +++
 rtl/shifter_sequencer_64.sv | 123 ++++++++++++
 tb/tb_shifter_sequencer_64.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/shifter_sequencer_64_if.sv
`default_nettype none
// ============================================================================
//  Module   : shifter_sequencer_64_if
//  Brief    : Request/result handshake bundle for the 64-bit shift sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface shifter_sequencer_64_if #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shamt;
    logic [2:0]         control;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   y;

    modport master (
        output in_valid, a, shamt, control, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, shamt, control, out_ready,
        output in_ready, out_valid, y
    );
endinterface
`default_nettype wire

// File: rtl/shifter_sequencer_64.sv
`default_nettype none
// ============================================================================
//  Module   : shifter_sequencer_64
//  Brief    : 64-bit shift/rotate built from two passes of a 32-bit funnel.
//  Revision : 1.0 - initial release
// ============================================================================
module shifter_sequencer_64 #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  wire logic             clk,
    input  wire logic             reset,
    shifter_sequencer_64_if.slave bus
);
    localparam int c_half = WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [SHAMT_W-1:0] r_shamt;
    logic [2:0]         r_control;
    logic [WIDTH-1:0]   r_y;

    logic [c_half-1:0]  w_lo;
    logic [c_half-1:0]  w_hi;
    logic [c_half-1:0]  w_fill;
    logic               w_rotate;
    logic               w_left;
    logic               w_arith;
    logic [1:0]         w_word;
    logic [1:0]         w_s5;
    logic [1:0]         w_bi;
    logic [1:0]         w_ci;
    logic [SHAMT_W-1:0] w_k;
    logic [c_half-1:0]  w_seq [4];
    logic [c_half-1:0]  w_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_next = ST_LO;
            ST_LO:   w_next = ST_HI;
            ST_HI:   w_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_lo     = r_a[c_half-1:0];
    assign w_hi     = r_a[WIDTH-1:c_half];
    assign w_rotate = (r_control[2:1] == 2'b01);
    assign w_left   = r_control[2] | (w_rotate & r_control[0]);
    assign w_arith  = (r_control == 3'b001);
    assign w_fill   = {c_half{w_arith & r_a[WIDTH-1]}};
    assign w_word   = {1'b0, (r_state == ST_HI)};
    assign w_s5     = {1'b0, r_shamt[SHAMT_W-1]};

    // The operand is laid out as a 4-word sequence with the fill (or the
    // wrapped words for rotates) beyond the operand; each result word is a
    // 64->32 funnel over two adjacent entries, offset by one word when s[5]=1.
    always_comb begin
        if (w_left) begin
            w_seq[0] = w_rotate ? w_lo : '0;
            w_seq[1] = w_rotate ? w_hi : '0;
            w_seq[2] = w_lo;
            w_seq[3] = w_hi;
            w_bi     = w_word - w_s5 + 2'd2;
            w_ci     = w_bi - 2'd1;
            w_k      = SHAMT_W'(c_half) - {1'b0, r_shamt[SHAMT_W-2:0]};
        end else begin
            w_seq[0] = w_lo;
            w_seq[1] = w_hi;
            w_seq[2] = w_rotate ? w_lo : w_fill;
            w_seq[3] = w_rotate ? w_hi : w_fill;
            w_ci     = w_word + w_s5;
            w_bi     = w_ci + 2'd1;
            w_k      = {1'b0, r_shamt[SHAMT_W-2:0]};
        end
        w_res = c_half'({w_seq[w_bi], w_seq[w_ci]} >> w_k);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_shamt   <= '0;
            r_control <= '0;
            r_y       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a       <= bus.a;
                        r_shamt   <= bus.shamt;
                        r_control <= bus.control;
                    end
                end
                ST_LO:   r_y[c_half-1:0]     <= w_res;
                ST_HI:   r_y[WIDTH-1:c_half] <= w_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.y         = r_y;
endmodule
`default_nettype wire

// File: tb/tb_shifter_sequencer_64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shifter_sequencer_64
//  Brief    : Directed and randomized checks of shifter_sequencer_64.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shifter_sequencer_64;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    shifter_sequencer_64_if bus ();

    shifter_sequencer_64 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shift(input logic [63:0] a, input int s,
                                              input logic [2:0] c);
        case (c)
            3'b000:  return a >> s;
            3'b001:  return 64'($signed(a) >>> s);
            3'b010:  return (a >> s) | (a << (64 - s));
            3'b011:  return (a << s) | (a >> (64 - s));
            default: return a << s;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for the result, hold it under
    // backpressure for 'hold' cycles, then consume it.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [5:0] s,
                          input logic [2:0] c, input logic [63:0] exp_y,
                          input int hold, input bit chk_lat);
        int n;
        check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.shamt    = s;
        bus.control  = c;
        step();
        n = 1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 20) begin
            bus.a        = {$urandom, $urandom};
            bus.shamt    = 6'($urandom);
            bus.control  = 3'($urandom);
            bus.in_valid = 1'($urandom);
            step();
            n++;
        end
        if (chk_lat) check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_y"}, bus.y, exp_y);
        repeat (hold) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'($urandom);
            bus.a         = {$urandom, $urandom};
            step();
            check({tag, "_hold_y"}, bus.y, exp_y);
            check({tag, "_hold_flags"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_after_flags"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    endtask

    initial begin
        logic [63:0] ra;
        logic [5:0]  rs;
        logic [2:0]  rc;
        logic        seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.shamt     = '0;
        bus.control   = '0;

        #1 reset = 1'b1;
        #2;
        check("reset_flags", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        check("reset_y", bus.y, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        run_op("lsr",    64'h8000_0000_0000_0001, 6'd4,  3'b000, 64'h0800_0000_0000_0000, 0, 1'b1);
        run_op("asr",    64'h8000_0000_0000_0001, 6'd36, 3'b001, 64'hFFFF_FFFF_F800_0000, 0, 1'b1);
        run_op("asr_pos",64'h7FFF_0000_0000_0000, 6'd48, 3'b001, 64'h0000_0000_0000_7FFF, 0, 1'b0);
        run_op("asl",    64'h0000_0000_0000_0001, 6'd63, 3'b101, 64'h8000_0000_0000_0000, 0, 1'b0);
        run_op("ror",    64'h0000_0000_0000_00FF, 6'd8,  3'b010, 64'hFF00_0000_0000_0000, 0, 1'b0);
        run_op("rol",    64'h8000_0000_0000_0001, 6'd1,  3'b011, 64'h0000_0000_0000_0003, 0, 1'b0);
        run_op("ror32",  64'h0123_4567_89AB_CDEF, 6'd32, 3'b010, 64'h89AB_CDEF_0123_4567, 0, 1'b0);
        run_op("lsl110", 64'h0000_0000_F000_0001, 6'd12, 3'b110, 64'h0000_0F00_0000_1000, 0, 1'b0);
        run_op("lsl111", 64'h0000_0000_0000_0001, 6'd40, 3'b111, 64'h0000_0100_0000_0000, 0, 1'b0);

        for (int c = 0; c < 8; c++) begin
            run_op("shamt0", 64'hDEAD_BEEF_0123_4567, 6'd0, 3'(c), 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
        end

        run_op("backpressure", 64'h0123_4567_89AB_CDEF, 6'd33, 3'b011, 64'h1357_9BDE_0246_8ACF, 5, 1'b0);
        run_op("after_bp",     64'h8000_0000_0000_0000, 6'd63, 3'b000, 64'h0000_0000_0000_0001, 0, 1'b0);

        // Abort a request while it sits in the high-word state.
        bus.in_valid = 1'b1;
        bus.a        = 64'hFFFF_0000_FFFF_0000;
        bus.shamt    = 6'd5;
        bus.control  = 3'b010;
        step();
        bus.in_valid = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        check("abort_flags", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        check("abort_y", bus.y, 64'd0);
        @(negedge clk) reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | bus.out_valid;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        run_op("post_abort", 64'h0000_0000_0000_00F0, 6'd4, 3'b000, 64'h0000_0000_0000_000F, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rs = 6'($urandom);
            rc = 3'($urandom);
            repeat ($urandom_range(0, 3)) begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'($urandom);
                step();
            end
            bus.out_ready = 1'b0;
            run_op("rand", ra, rs, rc, ref_shift(ra, int'(rs), rc), $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
